// File: rtl/score_counter.sv
// Per-player saturating win counter driving an active-low seven-segment digit.
// One point per rising edge with win high; count clears asynchronously on Reset low.
module score_counter #(
    parameter int unsigned MAX_SCORE = 7
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       win,
    output logic [6:0] hex
);

    localparam logic [3:0] MaxCount = 4'(MAX_SCORE);

    logic [3:0] r_count;
    logic [3:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (win && (r_count < MaxCount)) begin
            w_count_next = r_count + 4'd1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_count <= 4'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // Unregistered decode: hex follows the count with no extra cycle.
    always_comb begin
        hex = 7'b1111111;
        case (r_count)
            4'd0:    hex = 7'b1000000;
            4'd1:    hex = 7'b1111001;
            4'd2:    hex = 7'b0100100;
            4'd3:    hex = 7'b0110000;
            4'd4:    hex = 7'b0011001;
            4'd5:    hex = 7'b0010010;
            4'd6:    hex = 7'b0000010;
            4'd7:    hex = 7'b1111000;
            4'd8:    hex = 7'b0000000;
            4'd9:    hex = 7'b0010000;
            default: hex = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: a default instance (max 7) and a max-9 instance share the
// stimulus; both are checked against integer point totals and a digit pattern table.
module tb_score_counter;

    logic       Clock   = 1'b0;
    logic       Reset   = 1'b0;
    logic       win     = 1'b0;
    logic       clk_run = 1'b0;
    logic [6:0] hex7;
    logic [6:0] hex9;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          m7    = 0;
    int          m9    = 0;
    logic [6:0]  seg [16];

    always #5 if (clk_run) Clock = ~Clock;

    score_counter dut7 (
        .Clock (Clock),
        .Reset (Reset),
        .win   (win),
        .hex   (hex7)
    );

    score_counter #(.MAX_SCORE(9)) dut9 (
        .Clock (Clock),
        .Reset (Reset),
        .win   (win),
        .hex   (hex9)
    );

    task automatic check(input string tag);
        total++;
        assert (hex7 === seg[m7]) else begin
            bad++;
            $error("FAIL %s max7: got %b want %b", tag, hex7, seg[m7]);
        end
        total++;
        assert (hex9 === seg[m9]) else begin
            bad++;
            $error("FAIL %s max9: got %b want %b", tag, hex9, seg[m9]);
        end
    endtask

    task automatic check_const(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Drive win, take one rising edge, credit points if out of reset, check #1 later.
    task automatic step(input logic w, input string tag);
        win = w;
        @(posedge Clock);
        if (Reset && w) begin
            m7 = (m7 + 1 > 7) ? 7 : m7 + 1;
            m9 = (m9 + 1 > 9) ? 9 : m9 + 1;
        end
        #1;
        check(tag);
    endtask

    // Called just after a rising edge: pulse reset between edges and check before the next.
    task automatic pulse_reset(input string tag);
        Reset = 1'b0;
        m7 = 0;
        m9 = 0;
        #1;
        check(tag);
        Reset = 1'b1;
        #1;
    endtask

    initial begin
        seg[0] = 7'b1000000; seg[1] = 7'b1111001; seg[2] = 7'b0100100;
        seg[3] = 7'b0110000; seg[4] = 7'b0011001; seg[5] = 7'b0010010;
        seg[6] = 7'b0000010; seg[7] = 7'b1111000; seg[8] = 7'b0000000;
        seg[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) seg[i] = 7'b1111111;

        // Reset with the clock stopped.
        #3;
        check("reset_noclk");
        check_const("reset_noclk_const", hex7, 7'b1000000);

        clk_run = 1'b1;
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, "idle");
        check_const("idle_const", hex7, 7'b1000000);

        // Three single pulses with gaps.
        step(1'b1, "pulse1");
        check_const("pulse1_const", hex7, 7'b1111001);
        step(1'b0, "gap1");
        step(1'b0, "gap1b");
        step(1'b1, "pulse2");
        check_const("pulse2_const", hex7, 7'b0100100);
        step(1'b0, "gap2");
        step(1'b1, "pulse3");
        check_const("pulse3_const", hex7, 7'b0110000);
        step(1'b0, "gap3");

        // Four consecutive edges from zero.
        pulse_reset("rst_before_run");
        for (int i = 0; i < 4; i++) step(1'b1, "run4");
        check_const("run4_const", hex7, 7'b0011001);

        // Saturation: ten more edges high.
        pulse_reset("rst_before_sat");
        for (int i = 0; i < 10; i++) step(1'b1, "sat");
        check_const("sat7_const", hex7, 7'b1111000);
        check_const("sat9_const", hex9, 7'b0010000);
        step(1'b0, "sat_hold");

        // Async reset mid-count at 5, win high throughout reset.
        pulse_reset("rst_before_mid");
        for (int i = 0; i < 5; i++) step(1'b1, "to5");
        check_const("at5_const", hex7, 7'b0010010);
        Reset = 1'b0;
        m7 = 0;
        m9 = 0;
        #1;
        check("async_mid");
        check_const("async_mid_const", hex7, 7'b1000000);
        step(1'b1, "rst_hold_win");
        step(1'b1, "rst_hold_win2");
        Reset = 1'b1;
        step(1'b0, "rst_release");

        // Max-9 instance: 12 edges high, passes 8 then holds 9.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, "max9_run");
            if (i == 7) check_const("max9_eight", hex9, 7'b0000000);
        end
        check_const("max9_hold", hex9, 7'b0010000);

        // Random win with occasional async reset.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) pulse_reset("rand_rst");
            step(1'($urandom_range(0, 1)), "rand");
        end

        win = 1'b0;
        clk_run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_counter.md
# score_counter

Per-player win counter with a seven-segment display. Module name: `score_counter`. Each clock cycle in which `win` is sampled high adds one point, up to a saturating maximum. The current count is decoded onto an active-low seven-segment output. The tug-of-war match controller instantiates one copy per player and drives each copy's `win` with that player's one-cycle victory pulse.

## Interface
- `MAX_SCORE`, default 7: saturation value of the count. Legal range is 1..9.
- `Clock`  input  1  system clock; all state updates on the rising edge.
- `Reset`  input  1  asynchronous, active-low reset. Port is named `Reset` but asserts when low.
- `win`  input  1  synchronous increment request; one point per rising edge at which it is high.
- `hex`  output  7  active-low seven-segment pattern of the current count. Bit 0 = segment a, bit 6 = segment g.

## Operation
- State is a 4-bit unsigned register `count`, range 0..MAX_SCORE.
- Reset (`Reset`=0) forces `count`=0 immediately, independent of `Clock`.
- While `Reset`=1, at each rising `Clock` edge:
  - `win`=1 and `count`<MAX_SCORE: `count` <= `count`+1.
  - `win`=1 and `count`==MAX_SCORE: `count` holds. Saturation: no wrap to 0, no overflow.
  - `win`=0: `count` holds.
- `win` is level-sampled, with no edge detection. A `win` held high for N consecutive edges adds min(N, MAX_SCORE−`count`) points.
- `hex` is a purely combinational decode of `count`. The active-low patterns, written as bits [6:0], are:
  - 0=1000000
  - 1=1111001
  - 2=0100100
  - 3=0110000
  - 4=0011001
  - 5=0010010
  - 6=0000010
  - 7=1111000
  - 8=0000000
  - 9=0010000
- Any `count` value outside 0..9 decodes to 1111111 (blank). Such values are unreachable but must still be covered by the decode.
- Unknown or X on `win` while out of reset is a bench error. The design need not handle it.

## Timing
- Reset value: `count`=0 and `hex`=1000000. Both are valid as soon as `Reset` falls, with no clock required.
- Reset asserted mid-count clears to 0 asynchronously. Any `win` sampled on a clock edge during reset is discarded.
- Reset deassertion is synchronized externally. The first increment can occur on the first rising edge after `Reset` rises.
- Increment latency: `win` high at edge k gives the new `count`, and the new `hex`, after edge k. There is zero added combinational cycle.
- `hex` changes only on a rising `Clock` edge or on reset assertion. It is glitch-tolerant: it drives LEDs directly, so there is no registered output stage.

## Test plan
- Reset behaviour: `Reset`=0 with the clock stopped -> `hex`=1000000. Release reset, hold `win`=0 for 5 cycles -> `hex` stays 1000000.
- Single pulses: `win` high for 1 cycle, three times with gaps -> `hex` goes 1111001, then 0100100, then 0110000, each changing one edge after its pulse.
- Consecutive pulses: `win` held high 4 consecutive edges from 0 -> `hex` steps through 1..4 and ends at 0011001.
- Saturation: default MAX_SCORE=7, `win` high 10 edges -> `hex`=1111000 and stays there. No wrap to 1000000.
- Async reset mid-count: `count`=5 (`hex`=0010010), pull `Reset` low between clock edges -> `hex`=1000000 before the next edge. `win`=1 during reset does not increment.
- Parameter: MAX_SCORE=9, `win` high 12 edges -> `hex` passes 0000000 (8), then holds at 0010000 (9).
